// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS write-back stage and its neighbours.
package mips_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_REGS       = 32;
  localparam int REG_ZERO       = 0;

  // Read-port priority, identical for every port, highest first:
  //   1. Reset high                                    -> 0
  //   2. read index == REG_ZERO                        -> 0
  //   3. effective write && read index == write index  -> write-back value (bypass)
  //   4. otherwise                                     -> stored register value
  typedef enum logic [1:0] {
    RD_SRC_ZERO   = 2'd0,
    RD_SRC_BYPASS = 2'd1,
    RD_SRC_ARRAY  = 2'd2
  } rd_src_e;

  // Encode the read-port priority as a source selector.
  function automatic rd_src_e read_source(input logic reset,
                                          input logic addr_is_zero,
                                          input logic bypass_hit);
    rd_src_e src;
    if (reset) begin
      src = RD_SRC_ZERO;
    end else if (addr_is_zero) begin
      src = RD_SRC_ZERO;
    end else if (bypass_hit) begin
      src = RD_SRC_BYPASS;
    end else begin
      src = RD_SRC_ARRAY;
    end
    return src;
  endfunction

endpackage

// File: rtl/writeback_mux.sv
// MemToReg select: picks load data or ALU result as the write-back value.
module writeback_mux
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  mem_to_reg_i,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic [DATA_WIDTH-1:0] write_data_o
);

  // Select the write-back source.
  always_comb begin
    write_data_o = alu_result_i;
    if (mem_to_reg_i) begin
      write_data_o = read_data_i;
    end else begin
      write_data_o = alu_result_i;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage plus 2-read/1-write architectural register file with
// write-through bypass, committed-write export and retired-write counter.
module writeback_regfile
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  RegWrite_In,
  input  logic                  MemToReg_In,
  input  logic [DATA_WIDTH-1:0] ReadData_In,
  input  logic [DATA_WIDTH-1:0] ALUResult_In,
  input  logic [ADDR_WIDTH-1:0] RegDstMUX_In,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [DATA_WIDTH-1:0] WriteData_WB,
  output logic [ADDR_WIDTH-1:0] WriteRegister_WB,
  output logic                  RegWrite_WB,
  output logic [31:0]           WriteCount
);

  localparam int NUM_REGS_P = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] write_data_s;
  logic                  reg_write_wb_s;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS_P];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS_P];
  logic [31:0]           write_count_q;
  logic [31:0]           write_count_d;

  logic [1:0][ADDR_WIDTH-1:0] rd_addr_s;
  logic [1:0][DATA_WIDTH-1:0] rd_data_s;

  writeback_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_writeback_mux (
    .mem_to_reg_i (MemToReg_In),
    .read_data_i  (ReadData_In),
    .alu_result_i (ALUResult_In),
    .write_data_o (write_data_s)
  );

  // A write is effective only outside reset and never to the zero register.
  assign reg_write_wb_s   = RegWrite_In && (RegDstMUX_In != ADDR_WIDTH'(REG_ZERO)) && !Reset;

  assign WriteData_WB     = write_data_s;
  assign WriteRegister_WB = RegDstMUX_In;
  assign RegWrite_WB      = reg_write_wb_s;
  assign WriteCount       = write_count_q;

  // Next-state of the array and the retired-write counter.
  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (reg_write_wb_s) begin
      regs_d[RegDstMUX_In] = write_data_s;
      write_count_d        = write_count_q + 32'd1;
    end else begin
      write_count_d = write_count_q;
    end
  end

  // Commit state; reset clears everything and drops the write of that cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS_P; i++) begin
        regs_q[i] <= '0;
      end
      write_count_q <= 32'd0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  assign rd_addr_s[0] = ReadRegister1;
  assign rd_addr_s[1] = ReadRegister2;

  for (genvar p = 0; p < 2; p++) begin : g_read_port
    rd_src_e               src_s;
    logic [DATA_WIDTH-1:0] data_s;

    // Resolve one read port through the zero / bypass / array priority.
    always_comb begin
      src_s  = read_source(Reset,
                           rd_addr_s[p] == ADDR_WIDTH'(REG_ZERO),
                           reg_write_wb_s && (rd_addr_s[p] == RegDstMUX_In));
      data_s = '0;
      case (src_s)
        RD_SRC_ZERO:   data_s = '0;
        RD_SRC_BYPASS: data_s = write_data_s;
        RD_SRC_ARRAY:  data_s = regs_q[rd_addr_s[p]];
        default:       data_s = '0;
      endcase
    end

    assign rd_data_s[p] = data_s;
  end

  assign ReadData1 = rd_data_s[0];
  assign ReadData2 = rd_data_s[1];

endmodule
